// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU. A round-robin arbiter accepts one
// operation at a time in IDLE, the ALU result is registered in EXEC, and the
// result is held in RESP until the consumer takes it.
module alu_arbiter #(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [B-1:0] req0_op1,
    input  logic [B-1:0] req0_op2,
    input  logic [B-1:0] req1_op1,
    input  logic [B-1:0] req1_op2,
    input  logic [3:0]   req0_ctrl,
    input  logic [3:0]   req1_ctrl,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [B-1:0] resp_result,
    output logic         resp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_reg, state_next;
    logic         last_grant_reg;
    logic         grant;
    logic         accept;
    logic [B-1:0] op1_reg, op2_reg;
    logic [3:0]   ctrl_reg;
    logic         id_reg;
    logic [B-1:0] resp_result_reg;
    logic         resp_zero_reg;
    logic         resp_id_reg;
    logic [B-1:0] alu_out;

    // Arbitration and next-state: readys are combinational and only ever raised in IDLE.
    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant      = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                // With both asking, serve the one not served last; otherwise serve whoever asks.
                if (req0_valid && req1_valid) begin
                    grant = ~last_grant_reg;
                end else begin
                    grant = req1_valid;
                end
                // Readys are also masked while reset is held so nothing looks accepted.
                if ((req0_valid || req1_valid) && !reset) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ALU on the latched operands; unknown codes give all ones.
    always_comb begin
        alu_out = '1;
        case (ctrl_reg)
            4'b0010: alu_out = op1_reg + op2_reg;
            4'b0110: alu_out = op1_reg - op2_reg;
            4'b0000: alu_out = op1_reg & op2_reg;
            4'b0001: alu_out = op1_reg | op2_reg;
            4'b0111: alu_out = {{(B-1){1'b0}}, (op1_reg < op2_reg)};
            default: alu_out = '1;
        endcase
    end

    // State, grant pointer, operand latch and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            last_grant_reg  <= 1'b1;
            op1_reg         <= '0;
            op2_reg         <= '0;
            ctrl_reg        <= 4'b0000;
            id_reg          <= 1'b0;
            resp_result_reg <= '0;
            resp_zero_reg   <= 1'b0;
            resp_id_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                last_grant_reg <= grant;
                id_reg         <= grant;
                op1_reg        <= grant ? req1_op1 : req0_op1;
                op2_reg        <= grant ? req1_op2 : req0_op2;
                ctrl_reg       <= grant ? req1_ctrl : req0_ctrl;
            end
            if (state_reg == EXEC) begin
                resp_result_reg <= alu_out;
                resp_zero_reg   <= (alu_out == '0);
                resp_id_reg     <= id_reg;
            end
        end
    end

    assign resp_valid  = (state_reg == RESP);
    assign resp_result = resp_result_reg;
    assign resp_zero   = resp_zero_reg;
    assign resp_id     = resp_id_reg;

endmodule
